// File: rtl/mmio_bus_bridge_pkg.sv
// Shared types and constants for the processor data-memory / MMIO bridge.
// The FSM encoding and channel-field width helper live here so the decoder and top agree.
package mmio_bus_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    // Channel-select field sits between the RAM/MMIO select bit and the local offset.
    function automatic int ch_width(input int addr_w, input int off_w);
        return addr_w - 1 - off_w;
    endfunction

endpackage

// File: rtl/mmio_bus_bridge_addr_decode.sv
// Splits a processor dmem address into RAM/MMIO select, channel and offset,
// and flags whether the channel is one that is actually implemented.
module mmio_addr_decode
    import mmio_bus_bridge_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int OFF_W  = 8,
    parameter int NCH    = 4
) (
    input  logic [ADDR_W-1:0]       addr_i,
    output logic                    is_mmio_o,
    output logic [ADDR_W-OFF_W-2:0] ch_o,
    output logic [OFF_W-1:0]        off_o,
    output logic                    mapped_o
);

    localparam int CH_W = ch_width(ADDR_W, OFF_W);

    assign is_mmio_o = addr_i[ADDR_W-1];
    assign ch_o      = addr_i[OFF_W +: CH_W];
    assign off_o     = addr_i[OFF_W-1:0];
    // Extra bit so NCH == 2**CH_W does not wrap to zero.
    assign mapped_o  = is_mmio_o && ({1'b0, ch_o} < (CH_W+1)'(NCH));

endmodule

// File: rtl/mmio_bus_bridge.sv
// Bridge between the processor dmem port, the syncram and NCH MMIO channels.
// RAM accesses pass straight through; MMIO accesses stall for a req/ack handshake with timeout.
module mmio_bus_bridge
    import mmio_bus_bridge_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 12,
    parameter int                OFF_W    = 8,
    parameter int                NCH      = 4,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [ADDR_W-1:0]       proc_addr_i,
    input  logic [DATA_W-1:0]       proc_wdata_i,
    input  logic                    proc_wren_i,
    input  logic                    proc_rden_i,
    output logic [DATA_W-1:0]       proc_rdata_o,
    output logic                    proc_stall_o,
    output logic [ADDR_W-2:0]       ram_addr_o,
    output logic [DATA_W-1:0]       ram_data_o,
    output logic                    ram_wren_o,
    input  logic [DATA_W-1:0]       ram_q_i,
    output logic [NCH-1:0]          per_req_o,
    output logic                    per_we_o,
    output logic [OFF_W-1:0]        per_off_o,
    output logic [DATA_W-1:0]       per_wdata_o,
    input  logic [NCH-1:0]          per_ack_i,
    input  logic [NCH*DATA_W-1:0]   per_rdata_i,
    input  logic                    err_clr_i,
    output logic                    err_flag_o,
    output logic [ADDR_W-OFF_W-2:0] err_ch_o
);

    localparam int                CH_W     = ch_width(ADDR_W, OFF_W);
    localparam int                NSLOT    = 2**CH_W;
    localparam int                CNT_W    = $clog2(TIMEOUT+1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT-1);

    logic              dec_mmio;
    logic [CH_W-1:0]   dec_ch;
    logic [OFF_W-1:0]  dec_off;
    logic              dec_mapped;
    logic              access;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              we_q, we_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NCH-1:0]    req_q, req_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_flag_q, err_flag_d;
    logic [CH_W-1:0]   err_ch_q, err_ch_d;
    logic              err_set;
    logic [CH_W-1:0]   err_set_ch;

    // Ack/rdata widened to every encodable channel so ch_q indexes them without range checks.
    logic [NSLOT-1:0]  ack_ext;
    logic [DATA_W-1:0] slot_rdata [NSLOT];

    mmio_addr_decode #(
        .ADDR_W (ADDR_W),
        .OFF_W  (OFF_W),
        .NCH    (NCH)
    ) u_decode (
        .addr_i    (proc_addr_i),
        .is_mmio_o (dec_mmio),
        .ch_o      (dec_ch),
        .off_o     (dec_off),
        .mapped_o  (dec_mapped)
    );

    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
            if (gi < NCH) begin : g_impl
                assign ack_ext[gi]    = per_ack_i[gi];
                assign slot_rdata[gi] = per_rdata_i[gi*DATA_W +: DATA_W];
            end else begin : g_unimpl
                assign ack_ext[gi]    = 1'b0;
                assign slot_rdata[gi] = '0;
            end
        end
    endgenerate

    assign access       = proc_rden_i | proc_wren_i;
    assign ram_addr_o   = proc_addr_i[ADDR_W-2:0];
    assign ram_data_o   = proc_wdata_i;
    assign ram_wren_o   = proc_wren_i & ~proc_addr_i[ADDR_W-1];
    assign proc_rdata_o = (state_q == ST_DONE) ? rdata_q : ram_q_i;

    assign per_req_o    = req_q;
    assign per_we_o     = we_q;
    assign per_off_o    = off_q;
    assign per_wdata_o  = wdata_q;
    assign err_flag_o   = err_flag_q;
    assign err_ch_o     = err_ch_q;

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        we_d         = we_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        req_d        = req_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        err_set      = 1'b0;
        err_set_ch   = ch_q;
        proc_stall_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dec_mmio && access) begin
                    proc_stall_o = 1'b1;
                    if (dec_mapped) begin
                        ch_d    = dec_ch;
                        we_d    = proc_wren_i;
                        off_d   = dec_off;
                        wdata_d = proc_wdata_i;
                        for (int i = 0; i < NCH; i++) begin
                            req_d[i] = (dec_ch == CH_W'(i));
                        end
                        cnt_d   = '0;
                        state_d = ST_WAIT;
                    end else begin
                        rdata_d    = ERR_DATA;
                        err_set    = 1'b1;
                        err_set_ch = dec_ch;
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_WAIT: begin
                proc_stall_o = 1'b1;
                // An ack arriving in the expiry cycle still counts as a normal completion.
                if (ack_ext[ch_q]) begin
                    req_d = '0;
                    if (!we_q) begin
                        rdata_d = slot_rdata[ch_q];
                    end
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d      = '0;
                    rdata_d    = ERR_DATA;
                    err_set    = 1'b1;
                    err_set_ch = ch_q;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        err_flag_d = err_flag_q;
        err_ch_d   = err_ch_q;
        if (err_set) begin
            err_flag_d = 1'b1;
            err_ch_d   = err_set_ch;
        end else if (err_clr_i) begin
            err_flag_d = 1'b0;
            err_ch_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            we_q       <= 1'b0;
            off_q      <= '0;
            wdata_q    <= '0;
            req_q      <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_flag_q <= 1'b0;
            err_ch_q   <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            we_q       <= we_d;
            off_q      <= off_d;
            wdata_q    <= wdata_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_flag_q <= err_flag_d;
            err_ch_q   <= err_ch_d;
        end
    end

endmodule
